// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access; data has priority, streak-capped.
// Latency: eligible request at t -> mem_req_o at t+1 -> ack at t+1+k -> registered valid pulse at t+2+k.
// Backpressure: requesters hold req until their valid pulse; memory request held until mem_ack_i.
module unified_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_kill_i,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_stall_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  input  logic [3:0]    d_strb_i,
  output logic          d_valid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    mem_strb_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          kill_q, kill_d;

  logic if_elig, d_elig;
  logic f_cand, d_cand;
  logic arb_slot;
  logic grant_f, grant_d;
  logic if_done, d_done;

  assign if_stall_o = if_req_i & ~if_valid_o;
  assign d_stall_o  = d_req_i & ~d_valid_o;

  // A requester whose valid is pulsing this cycle has already been served.
  assign if_elig = if_req_i & ~if_valid_o;
  assign d_elig  = d_req_i & ~d_valid_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      kill_q   <= kill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    kill_d   = kill_q;
    grant_f  = 1'b0;
    grant_d  = 1'b0;
    if_done  = 1'b0;
    d_done   = 1'b0;

    // In an ack cycle the owner's valid has not pulsed yet, so it is excluded here.
    f_cand   = if_elig & (state_q != BUSY_I);
    d_cand   = d_elig & (state_q != BUSY_D);
    arb_slot = (state_q == IDLE) | mem_ack_i;

    case (state_q)
      BUSY_I: begin
        kill_d = kill_q | if_kill_i;
        if (mem_ack_i) begin
          if_done = ~kill_d;
          kill_d  = 1'b0;
        end
      end
      BUSY_D: begin
        d_done = mem_ack_i;
      end
      default: begin
        kill_d = 1'b0;
      end
    endcase

    if (arb_slot) begin
      if (f_cand && (!d_cand || streak_q == STREAK_MAX)) begin
        grant_f = 1'b1;
      end else if (d_cand) begin
        grant_d = 1'b1;
      end

      if (grant_f) begin
        state_d  = BUSY_I;
        streak_d = '0;
      end else if (grant_d) begin
        state_d = BUSY_D;
        if (!f_cand) begin
          streak_d = '0;
        end else if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + 1'b1;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid_o  <= 1'b0;
      if_rdata_o  <= '0;
      d_valid_o   <= 1'b0;
      d_rdata_o   <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_strb_o  <= 4'h0;
    end else begin
      if_valid_o <= if_done;
      d_valid_o  <= d_done;
      if (if_done) begin
        if_rdata_o <= mem_rdata_i;
      end
      // Stores complete without disturbing the last load result.
      if (d_done && !mem_we_o) begin
        d_rdata_o <= mem_rdata_i;
      end

      if (grant_f) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
        mem_strb_o  <= 4'h0;
      end else if (grant_d) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= d_we_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_we_i ? d_wdata_i : '0;
        mem_strb_o  <= d_we_i ? d_strb_i : 4'h0;
      end else if (arb_slot) begin
        mem_req_o   <= 1'b0;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= '0;
        mem_wdata_o <= '0;
        mem_strb_o  <= 4'h0;
      end
    end
  end

endmodule
